// File: rtl/fnd_scan_controller_if.sv
// Bundle between the stopwatch datapath (master) and the FND scan controller (slave).
// It carries the time fields and mode in, and the common/segment drive out.
interface fnd_scan_controller_if;
   logic       mode;
   logic [6:0] msec;
   logic [5:0] sec;
   logic [5:0] min;
   logic [4:0] hour;
   logic [3:0] fnd_com;
   logic [7:0] fnd_data;

   modport master (
      output mode, msec, sec, min, hour,
      input  fnd_com, fnd_data
   );

   modport slave (
      input  mode, msec, sec, min, hour,
      output fnd_com, fnd_data
   );
endinterface

// File: rtl/fnd_scan_controller.sv
// 4-digit common-anode 7-segment scanner for the stopwatch: time-multiplexes the digits,
// splits the fields into tens/ones, and blinks the digit-2 decimal point at 1 Hz.
module fnd_scan_controller #(
   parameter int SCAN_COUNT   = 100_000,
   parameter int BLANK_CYCLES = 1_000
) (
   input  logic                 clk,
   input  logic                 reset,
   fnd_scan_controller_if.slave io_bus
);

   localparam int             CW        = $clog2(SCAN_COUNT);
   localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_COUNT - 1);

   logic [CW-1:0] r_counter;
   logic [1:0]    r_digit_sel;
   logic [3:0]    r_fnd_com;
   logic [7:0]    r_fnd_data;

   logic [6:0]    w_field_lo;
   logic [6:0]    w_field_hi;
   logic [6:0]    w_field;
   logic [6:0]    w_digit;
   logic [7:0]    w_seg;
   logic          w_dp_on;
   logic          w_blank;
   logic [3:0]    w_com_next;
   logic [7:0]    w_data_next;

   function automatic logic [7:0] seg7(input logic [6:0] d);
      logic [7:0] s;
      case (d)
         7'd0:    s = 8'hC0;
         7'd1:    s = 8'hF9;
         7'd2:    s = 8'hA4;
         7'd3:    s = 8'hB0;
         7'd4:    s = 8'h99;
         7'd5:    s = 8'h92;
         7'd6:    s = 8'h82;
         7'd7:    s = 8'hF8;
         7'd8:    s = 8'h80;
         7'd9:    s = 8'h90;
         default: s = 8'hBF;
      endcase
      return s;
   endfunction

   // Digits 0/1 come from the low field, digits 2/3 from the high field; odd digits are tens.
   assign w_field_lo  = io_bus.mode ? {1'b0, io_bus.min}  : io_bus.msec;
   assign w_field_hi  = io_bus.mode ? {2'b0, io_bus.hour} : {1'b0, io_bus.sec};
   assign w_field     = r_digit_sel[1] ? w_field_hi : w_field_lo;
   assign w_digit     = r_digit_sel[0] ? (w_field / 7'd10) : (w_field % 7'd10);
   assign w_seg       = seg7(w_digit);
   assign w_dp_on     = (r_digit_sel == 2'd2) && (io_bus.msec < 7'd50);
   assign w_data_next = {w_seg[7] & ~w_dp_on, w_seg[6:0]};

   generate
      if (BLANK_CYCLES == 0) begin : g_no_blank
         assign w_blank = 1'b0;
      end else begin : g_blank
         localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYCLES);
         assign w_blank = (r_counter < BLANK_LIM);
      end
   endgenerate

   // One-hot-low decode; blanking forces every common off.
   for (genvar gi = 0; gi < 4; gi++) begin : g_com
      assign w_com_next[gi] = w_blank | (r_digit_sel != 2'(gi));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_counter   <= '0;
         r_digit_sel <= 2'd0;
         r_fnd_com   <= 4'b1111;
         r_fnd_data  <= 8'hFF;
      end else begin
         if (r_counter == SCAN_LAST) begin
            r_counter   <= '0;
            r_digit_sel <= r_digit_sel + 2'd1;
         end else begin
            r_counter <= r_counter + 1'b1;
         end
         r_fnd_com  <= w_com_next;
         r_fnd_data <= w_data_next;
      end
   end

   assign io_bus.fnd_com  = r_fnd_com;
   assign io_bus.fnd_data = r_fnd_data;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Bench for fnd_scan_controller with a short scan (4 cycles/slot, 1 blank cycle):
// fixed digit vectors, mode toggle, mid-scan reset, and randomized inputs against a model.
module tb_fnd_scan_controller;
   localparam int SC = 4;
   localparam int BC = 1;
   localparam int NV = 7;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fnd_scan_controller_if bus ();

   fnd_scan_controller #(
      .SCAN_COUNT   (SC),
      .BLANK_CYCLES (BC)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .io_bus (bus)
   );

   typedef struct {
      logic             mode;
      int               msec;
      int               sec;
      int               min;
      int               hour;
      logic [3:0][7:0]  d;
   } vec_t;

   vec_t vecs [NV];
   int   n_pass  = 0;
   int   n_total = 0;
   int   s       = 0;   // position in the 4-digit scan frame, as seen by the next edge

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %02h, expected %02h", name, act, exp);
   endtask

   function automatic logic [7:0] model_data(input logic m, input int ms, input int se,
                                             input int mi, input int ho, input int sel);
      logic [7:0] codes [10];
      logic [7:0] d;
      int         val;
      int         dig;
      codes = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
      val   = (sel < 2) ? (m ? mi : ms) : (m ? ho : se);
      dig   = (sel % 2 == 1) ? val / 10 : val % 10;
      d     = (dig > 9) ? 8'hBF : codes[dig];
      if (sel == 2 && ms < 50) d[7] = 1'b0;
      return d;
   endfunction

   // One clock: predict from current inputs and frame position, then sample #1 after the edge.
   task automatic step(output int sel, output int cnt, output logic [3:0] exp_com,
                       output logic [7:0] exp_data);
      cnt      = s % SC;
      sel      = s / SC;
      exp_com  = (cnt < BC) ? 4'hF : ~(4'b0001 << sel);
      exp_data = model_data(bus.mode, int'(bus.msec), int'(bus.sec), int'(bus.min),
                            int'(bus.hour), sel);
      @(posedge clk);
      #1;
      s = (s + 1) % (4 * SC);
   endtask

   task automatic set_inputs(input logic m, input int ms, input int se, input int mi, input int ho);
      bus.mode = m;
      bus.msec = 7'(ms);
      bus.sec  = 6'(se);
      bus.min  = 6'(mi);
      bus.hour = 5'(ho);
   endtask

   initial begin
      int         sel;
      int         cnt;
      logic [3:0] ec;
      logic [7:0] ed;
      bit         found;

      vecs[0] = '{1'b0,  42, 37,  0,  0, {8'hB0, 8'h78, 8'h99, 8'hA4}};
      vecs[1] = '{1'b1,  75,  0,  5, 23, {8'hA4, 8'hB0, 8'hC0, 8'h92}};
      vecs[2] = '{1'b0, 120,  0,  0,  0, {8'hC0, 8'hC0, 8'hBF, 8'hC0}};
      vecs[3] = '{1'b0,   0, 59,  0,  0, {8'h92, 8'h10, 8'hC0, 8'hC0}};
      vecs[4] = '{1'b1,  49,  0, 59, 12, {8'hF9, 8'h24, 8'h92, 8'h90}};
      vecs[5] = '{1'b0,  50,  8,  0,  0, {8'hC0, 8'h80, 8'h92, 8'hC0}};
      vecs[6] = '{1'b1,  99,  0, 63, 31, {8'hB0, 8'hF9, 8'h82, 8'hB0}};

      reset = 1'b1;
      set_inputs(1'b0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      check("reset_com",  {4'h0, bus.fnd_com}, 8'h0F);
      check("reset_data", bus.fnd_data, 8'hFF);
      $display("reset: com=%04b data=%02h", bus.fnd_com, bus.fnd_data);
      reset = 1'b0;
      s     = 0;

      // Fixed vectors: a full frame each, data checked on every cycle including blank ones.
      for (int i = 0; i < NV; i++) begin
         set_inputs(vecs[i].mode, vecs[i].msec, vecs[i].sec, vecs[i].min, vecs[i].hour);
         for (int k = 0; k < 4 * SC; k++) begin
            step(sel, cnt, ec, ed);
            check($sformatf("vec%0d_com_k%0d", i, k), {4'h0, bus.fnd_com}, {4'h0, ec});
            check($sformatf("vec%0d_data_d%0d", i, sel), bus.fnd_data, vecs[i].d[sel]);
         end
         $display("vec %0d: mode=%0d msec=%0d sec=%0d min=%0d hour=%0d", i, vecs[i].mode,
                  vecs[i].msec, vecs[i].sec, vecs[i].min, vecs[i].hour);
      end

      // Mode toggle mid-slot on digit 3: data follows one edge later, common stays put.
      set_inputs(1'b0, 0, 59, 0, 12);
      found = 1'b0;
      for (int k = 0; k < 4 * SC && !found; k++) begin
         step(sel, cnt, ec, ed);
         if (sel == 3 && cnt == 1) found = 1'b1;
      end
      n_total++;
      if (found) n_pass++;
      else $display("FAIL toggle_find: digit 3 slot not reached, expected within %0d cycles", 4 * SC);
      check("toggle_pre_com",  {4'h0, bus.fnd_com}, 8'h07);
      check("toggle_pre_data", bus.fnd_data, 8'h92);
      bus.mode = 1'b1;
      #2;
      check("toggle_hold_data", bus.fnd_data, 8'h92);
      step(sel, cnt, ec, ed);
      check("toggle_post_com",  {4'h0, bus.fnd_com}, 8'h07);
      check("toggle_post_data", bus.fnd_data, 8'hF9);
      $display("mode toggle: com=%04b data=%02h", bus.fnd_com, bus.fnd_data);

      // Reset while digit 2 is lit: outputs drop without waiting for a clock edge.
      set_inputs(1'b0, 10, 34, 0, 0);
      found = 1'b0;
      for (int k = 0; k < 4 * SC && !found; k++) begin
         step(sel, cnt, ec, ed);
         if (sel == 2 && cnt == 2) found = 1'b1;
      end
      n_total++;
      if (found) n_pass++;
      else $display("FAIL rst_find: digit 2 slot not reached, expected within %0d cycles", 4 * SC);
      check("rst_pre_com", {4'h0, bus.fnd_com}, 8'h0B);
      #2;
      reset = 1'b1;
      #1;
      check("rst_async_com",  {4'h0, bus.fnd_com}, 8'h0F);
      check("rst_async_data", bus.fnd_data, 8'hFF);
      @(posedge clk);
      #1;
      reset = 1'b0;
      s     = 0;
      step(sel, cnt, ec, ed);
      check("rst_restart_blank", {4'h0, bus.fnd_com}, 8'h0F);
      step(sel, cnt, ec, ed);
      check("rst_restart_com",  {4'h0, bus.fnd_com}, 8'h0E);
      check("rst_restart_data", bus.fnd_data, ed);
      $display("mid-scan reset: restart com=%04b data=%02h", bus.fnd_com, bus.fnd_data);

      // Randomized inputs, changed on roughly a quarter of the cycles.
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 3) == 0)
            set_inputs(1'($urandom_range(0, 1)), int'($urandom_range(0, 127)),
                       int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                       int'($urandom_range(0, 31)));
         step(sel, cnt, ec, ed);
         check($sformatf("rand%0d_com", k),  {4'h0, bus.fnd_com}, {4'h0, ec});
         check($sformatf("rand%0d_data", k), bus.fnd_data, ed);
      end
      $display("random: 400 cycles applied");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
